// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the memory-stage load/store unit.
// Sizes follow the ISA funct3 low bits; reserved size 2'b11 is never aligned.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  typedef struct packed {
    logic load;
    logic word_store;
    logic sub_store;
    logic fault;
  } req_dec_t;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane select and sign/zero extension of a little-endian RAM word.
// Kept standalone so a cache refill path can share it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] ram_word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_sign;
  logic        half_sign;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = ram_word[7:0];
      2'd1:    byte_sel = ram_word[15:8];
      2'd2:    byte_sel = ram_word[23:16];
      default: byte_sel = ram_word[31:24];
    endcase
    half_sel  = addr_lo[1] ? ram_word[31:16] : ram_word[15:0];
    byte_sign = ~is_unsigned & byte_sel[7];
    half_sign = ~is_unsigned & half_sel[15];
  end

  always_comb begin
    case (size)
      SZ_BYTE: data_out = {{24{byte_sign}}, byte_sel};
      SZ_HALF: data_out = {{16{half_sign}}, half_sel};
      default: data_out = ram_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between EX/MEM and a single-port word RAM.
// Sub-word stores read, merge into merge_q, then write on a second cycle.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          stall,
  output logic          load_valid,
  output logic [DW-1:0] load_data,
  output logic          misalign,
  output logic          ram_we,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic [0:0]    state_q, state_d;
  logic          load_valid_q, load_valid_d;
  logic          misalign_q, misalign_d;
  logic [DW-1:0] load_data_q, load_data_d;
  logic [DW-1:0] merge_q, merge_d;
  logic [AW-1:0] addr_q, addr_d;

  logic [AW-1:0] word_adr;
  logic          aligned;
  logic [DW-1:0] load_ext;
  logic [DW-1:0] merged;
  req_dec_t      dec;

  assign word_adr = {req_addr[AW-1:2], 2'b00};
  assign aligned  = is_aligned(req_size, req_addr[1:0]);

  always_comb begin
    dec            = '0;
    dec.fault      = req_valid & ~aligned;
    dec.load       = req_valid & aligned & ~req_we;
    dec.word_store = req_valid & aligned & req_we & (req_size == SZ_WORD);
    dec.sub_store  = req_valid & aligned & req_we & (req_size != SZ_WORD);
  end

  load_align u_load_align (
    .ram_word    (ram_dout),
    .addr_lo     (req_addr[1:0]),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .data_out    (load_ext)
  );

  // Replace only the addressed lane; the rest of the word comes from the RAM read.
  always_comb begin
    merged = ram_dout;
    if (req_size == SZ_BYTE) begin
      case (req_addr[1:0])
        2'd0:    merged[7:0]   = req_wdata[7:0];
        2'd1:    merged[15:8]  = req_wdata[7:0];
        2'd2:    merged[23:16] = req_wdata[7:0];
        default: merged[31:24] = req_wdata[7:0];
      endcase
    end else if (req_addr[1]) begin
      merged[31:16] = req_wdata[15:0];
    end else begin
      merged[15:0] = req_wdata[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    merge_d      = merge_q;
    addr_d       = addr_q;
    load_valid_d = 1'b0;
    misalign_d   = 1'b0;
    load_data_d  = load_data_q;
    case (state_q)
      ST_IDLE: begin
        if (dec.load) begin
          load_valid_d = 1'b1;
          load_data_d  = load_ext;
        end
        misalign_d = dec.fault;
        if (dec.sub_store) begin
          state_d = ST_WRITE;
          merge_d = merged;
          addr_d  = word_adr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset suppresses any write in flight, including the second half of a merge.
  always_comb begin
    stall   = 1'b0;
    ram_we  = 1'b0;
    ram_adr = word_adr;
    ram_din = req_wdata;
    if (state_q == ST_WRITE) begin
      ram_we  = ~rst;
      ram_adr = addr_q;
      ram_din = merge_q;
    end else if (!rst) begin
      ram_we = dec.word_store;
      stall  = dec.sub_store;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      load_data_q  <= '0;
      merge_q      <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
      load_data_q  <= load_data_d;
      merge_q      <= merge_d;
      addr_q       <= addr_d;
    end
  end

  assign load_valid = load_valid_q;
  assign misalign   = misalign_q;
  assign load_data  = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, multi-cycle corner sequences,
// and random traffic checked against a byte-array memory model.
module tb_mem_access_unit;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          stall;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          misalign;
  logic          ram_we;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic [31:0] ram_mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;

  logic [7:0]  ref_mem [0:1023];
  logic [31:0] last_load;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic        exp_mis;
    logic        exp_lv;
    logic [31:0] exp_data;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs [12];

  mem_access_unit #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .misalign     (misalign),
    .ram_we       (ram_we),
    .ram_adr      (ram_adr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  always #5 clk = ~clk;

  assign ram_dout = ram_mem[ram_adr[9:2]];

  always @(posedge clk) begin
    if (pre_we) ram_mem[pre_idx] <= pre_data;
    else if (ram_we) ram_mem[ram_adr[9:2]] <= ram_din;
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [9:0] a);
    logic [9:0] base;
    base = {a[9:2], 2'b00};
    return {ref_mem[base + 10'd3], ref_mem[base + 10'd2], ref_mem[base + 10'd1], ref_mem[base]};
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns, input logic [9:0] a);
    int          n;
    logic [31:0] v;
    n = 1 << size;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + 10'(i)]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic preload_word(input logic [7:0] idx, input logic [31:0] data);
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = data;
    for (int i = 0; i < 4; i++) ref_mem[{idx, 2'b00} + 10'(i)] = 8'(data >> (8 * i));
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  // Called one time unit after a rising edge with the unit idle; returns likewise.
  task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [9:0] a, input logic [31:0] wdata,
                                output logic o_stall, output logic o_mis, output logic o_lv,
                                output logic [31:0] o_data, output logic [31:0] o_din);
    int          n;
    logic        fault;
    logic        sub;
    logic [31:0] exp_load;
    logic [31:0] exp_word;
    logic [31:0] exp_adr;
    n        = 1 << size;
    fault    = (size == 2'b11) || ((int'(a) % n) != 0);
    sub      = we && !fault && (n < 4);
    exp_load = (fault || we) ? last_load : model_load(size, uns, a);
    if (we && !fault)
      for (int i = 0; i < n; i++) ref_mem[a + 10'(i)] = 8'(wdata >> (8 * i));
    exp_word = model_word(a);
    exp_adr  = {22'b0, a[9:2], 2'b00};

    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = {22'b0, a};
    req_wdata    = wdata;

    @(negedge clk);
    o_stall = stall;
    o_din   = ram_din;
    check_output("req_stall", 32'(stall), 32'(sub));
    check_output("req_ram_we", 32'(ram_we), 32'(we && !fault && !sub));
    check_output("req_ram_adr", ram_adr, exp_adr);
    if (we && !fault && !sub) check_output("word_din", ram_din, wdata);

    if (sub) begin
      @(posedge clk);
      #1;
      o_din = ram_din;
      check_output("write_stall", 32'(stall), 32'd0);
      check_output("write_ram_we", 32'(ram_we), 32'd1);
      check_output("write_ram_adr", ram_adr, exp_adr);
      check_output("write_ram_din", ram_din, exp_word);
    end

    @(posedge clk);
    #1;
    req_valid = 1'b0;
    o_mis  = misalign;
    o_lv   = load_valid;
    o_data = load_data;
    check_output("load_valid", 32'(load_valid), 32'(!we && !fault));
    check_output("misalign", 32'(misalign), 32'(fault));
    check_output("load_data", load_data, exp_load);
    last_load = exp_load;

    @(posedge clk);
    #1;
    check_output("lv_pulse_end", 32'(load_valid), 32'd0);
    check_output("mis_pulse_end", 32'(misalign), 32'd0);
  endtask

  initial begin
    logic        o_stall, o_mis, o_lv;
    logic [31:0] o_data, o_din, exp;

    vecs[0]  = '{1'b0, 2'b00, 1'b0, 10'h103, 32'h0,         1'b0, 1'b0, 1'b1, 32'hFFFF_FF88, 32'h0};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 10'h103, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0088, 32'h0};
    vecs[2]  = '{1'b0, 2'b01, 1'b0, 10'h102, 32'h0,         1'b0, 1'b0, 1'b1, 32'hFFFF_8877, 32'h0};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 10'h100, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_6655, 32'h0};
    vecs[4]  = '{1'b1, 2'b10, 1'b0, 10'h200, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0000_6655, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 2'b10, 1'b0, 10'h200, 32'h0,         1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 10'h201, 32'hABCD_EF12, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_12EF};
    vecs[7]  = '{1'b1, 2'b01, 1'b0, 10'h202, 32'h9999_3456, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h3456_12EF};
    vecs[8]  = '{1'b0, 2'b10, 1'b0, 10'h200, 32'h0,         1'b0, 1'b0, 1'b1, 32'h3456_12EF, 32'h0};
    vecs[9]  = '{1'b0, 2'b01, 1'b0, 10'h101, 32'h0,         1'b0, 1'b1, 1'b0, 32'h3456_12EF, 32'h0};
    vecs[10] = '{1'b1, 2'b10, 1'b0, 10'h202, 32'h1111_2222, 1'b0, 1'b1, 1'b0, 32'h3456_12EF, 32'h0};
    vecs[11] = '{1'b0, 2'b11, 1'b0, 10'h100, 32'h0,         1'b0, 1'b1, 1'b0, 32'h3456_12EF, 32'h0};

    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    pre_we       = 1'b0;
    pre_idx      = '0;
    pre_data     = '0;
    last_load    = 32'h0;

    @(posedge clk);
    #1;
    for (int w = 0; w < 256; w++) preload_word(8'(w), $urandom);
    preload_word(8'h40, 32'h8877_6655);

    check_output("rst_load_valid", 32'(load_valid), 32'd0);
    check_output("rst_misalign", 32'(misalign), 32'd0);
    check_output("rst_load_data", load_data, 32'd0);
    check_output("rst_stall", 32'(stall), 32'd0);
    check_output("rst_ram_we", 32'(ram_we), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    for (int v = 0; v < 12; v++) begin
      apply_stimulus(vecs[v].we, vecs[v].size, vecs[v].uns, vecs[v].addr, vecs[v].wdata,
                     o_stall, o_mis, o_lv, o_data, o_din);
      check_output($sformatf("vec%0d_stall", v), 32'(o_stall), 32'(vecs[v].exp_stall));
      check_output($sformatf("vec%0d_mis", v), 32'(o_mis), 32'(vecs[v].exp_mis));
      check_output($sformatf("vec%0d_lv", v), 32'(o_lv), 32'(vecs[v].exp_lv));
      check_output($sformatf("vec%0d_data", v), o_data, vecs[v].exp_data);
      if (vecs[v].we && !vecs[v].exp_mis)
        check_output($sformatf("vec%0d_din", v), o_din, vecs[v].exp_din);
    end

    // Sub-word store followed with no gap by a load of the same word.
    $display("[TB] sb then immediate lw");
    ref_mem[10'h206] = 8'hA5;
    exp = model_word(10'h204);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h206; req_wdata = 32'h0000_00A5;
    #4;
    check_output("b2b_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    check_output("b2b_write_din", ram_din, exp);
    check_output("b2b_write_we", 32'(ram_we), 32'd1);
    @(posedge clk);
    #1;
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h204;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_output("b2b_load_valid", 32'(load_valid), 32'd1);
    check_output("b2b_load_data", load_data, exp);
    last_load = exp;
    @(posedge clk);
    #1;
    check_output("b2b_lv_end", 32'(load_valid), 32'd0);

    // Reset arriving during the write half of a sub-word store drops it.
    $display("[TB] reset during WRITE");
    exp = model_word(10'h300);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00;
    req_addr = 32'h301; req_wdata = 32'h0000_0055;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_output("rstw_ram_we", 32'(ram_we), 32'd0);
    check_output("rstw_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    check_output("rstw_load_valid", 32'(load_valid), 32'd0);
    check_output("rstw_misalign", 32'(misalign), 32'd0);
    check_output("rstw_load_data", load_data, 32'd0);
    check_output("rstw_idle_stall", 32'(stall), 32'd0);
    check_output("rstw_idle_we", 32'(ram_we), 32'd0);
    check_output("rstw_ram_word", ram_mem[8'hC0], exp);
    last_load = 32'h0;
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 2'b10, 1'b0, 10'h300, 32'h0, o_stall, o_mis, o_lv, o_data, o_din);

    $display("[TB] random traffic");
    for (int k = 0; k < 200; k++) begin
      logic [9:0] a;
      a = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      apply_stimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     a, $urandom, o_stall, o_mis, o_lv, o_data, o_din);
    end

    for (int w = 0; w < 256; w++)
      check_output($sformatf("ram_word_%0d", w), ram_mem[8'(w)], model_word(10'(w * 4)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
